// File: rtl/stall_forward_ctrl.sv
// Hazard scoreboard for the D stage: stall, operand forward selects
// and MAD busy tracking across NSTAGE post-decode stages.
module stall_forward_ctrl #(
  parameter int NSTAGE   = 3,
  parameter int RW       = 5,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int FW       = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic          d_rs_use,
  input  logic          d_rt_use,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [RW-1:0] d_a3,
  input  logic          d_wen,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_mad_start,
  input  logic          d_mad_div,
  input  logic          d_mad_use,
  input  logic          flush,
  output logic          stall,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic          mad_busy
);

  localparam int MC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW = $clog2(MC + 1);

  logic          r_v    [1:NSTAGE];
  logic [RW-1:0] r_a3   [1:NSTAGE];
  logic [TW-1:0] r_tnew [1:NSTAGE];
  logic [CW-1:0] r_cnt;

  logic          w_rs_hit;
  logic          w_rt_hit;
  logic [FW-1:0] w_rs_k;
  logic [FW-1:0] w_rt_k;
  logic [TW-1:0] w_rs_tn;
  logic [TW-1:0] w_rt_tn;
  logic          w_rs_st;
  logic          w_rt_st;
  logic          w_stall;
  logic          w_mad_ld;

  // Youngest-match search: scan old to young so the smallest k wins.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    w_rs_k   = '0;
    w_rt_k   = '0;
    w_rs_tn  = '0;
    w_rt_tn  = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (d_rs_use && d_rs != '0 &&
          r_v[k] && r_a3[k] == d_rs) begin
        w_rs_hit = 1'b1;
        w_rs_k   = FW'(k);
        w_rs_tn  = r_tnew[k];
      end
      if (d_rt_use && d_rt != '0 &&
          r_v[k] && r_a3[k] == d_rt) begin
        w_rt_hit = 1'b1;
        w_rt_k   = FW'(k);
        w_rt_tn  = r_tnew[k];
      end
    end
  end

  assign w_rs_st  = w_rs_hit && (w_rs_tn > d_rs_tuse);
  assign w_rt_st  = w_rt_hit && (w_rt_tn > d_rt_tuse);
  assign mad_busy = (r_cnt != '0);
  assign w_stall  = d_valid && !flush &&
                    (w_rs_st || w_rt_st ||
                     (d_mad_use && mad_busy));
  assign stall    = w_stall;
  assign fwd_rs   = (w_rs_hit && w_rs_tn == '0) ? w_rs_k : '0;
  assign fwd_rt   = (w_rt_hit && w_rt_tn == '0) ? w_rt_k : '0;
  assign w_mad_ld = d_valid && d_mad_start &&
                    !w_stall && !flush;

  // Scoreboard shift with saturating tnew; s[1] takes D or a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        r_v[k]    <= 1'b0;
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      for (int k = NSTAGE; k >= 2; k--) begin
        r_v[k]    <= r_v[k-1];
        r_a3[k]   <= r_a3[k-1];
        r_tnew[k] <= (r_tnew[k-1] != '0) ?
                     r_tnew[k-1] - TW'(1) : '0;
      end
      if (flush || w_stall || !d_valid) begin
        r_v[1]    <= 1'b0;
        r_a3[1]   <= '0;
        r_tnew[1] <= '0;
      end else begin
        r_v[1]    <= d_wen && (d_a3 != '0);
        r_a3[1]   <= d_a3;
        r_tnew[1] <= d_tnew;
      end
    end
  end

  // MAD busy counter; a started op runs to completion across flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_mad_ld) begin
      r_cnt <= d_mad_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_stall_forward_ctrl.sv
// Directed bench for stall_forward_ctrl with hand-computed
// stall/forward/busy expectations at default parameters.
module tb_stall_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_a3;
  logic       d_rs_use, d_rt_use;
  logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_wen;
  logic       d_mad_start, d_mad_div, d_mad_use;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
  logic       mad_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stall_forward_ctrl dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_a3(d_a3), .d_wen(d_wen), .d_tnew(d_tnew),
    .d_mad_start(d_mad_start), .d_mad_div(d_mad_div),
    .d_mad_use(d_mad_use), .flush(flush),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .mad_busy(mad_busy)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic clr();
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_a3 = '0;
    d_rs_use = 1'b0; d_rt_use = 1'b0;
    d_rs_tuse = '0; d_rt_tuse = '0; d_tnew = '0;
    d_wen = 1'b0; d_mad_start = 1'b0;
    d_mad_div = 1'b0; d_mad_use = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a3, input int tn);
    clr();
    d_valid = 1'b1; d_wen = 1'b1;
    d_a3 = 5'(a3); d_tnew = 3'(tn);
  endtask

  task automatic rd(input int rs, input int rs_tu,
                    input int rt, input int rt_tu);
    clr();
    d_valid = 1'b1;
    d_rs = 5'(rs); d_rs_use = 1'b1; d_rs_tuse = 3'(rs_tu);
    d_rt = 5'(rt); d_rt_use = 1'b1; d_rt_tuse = 3'(rt_tu);
  endtask

  task automatic drain();
    clr();
    repeat (4) step();
  endtask

  initial begin
    clr();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs", fwd_rs, 0);
    chk("rst_fwd_rt", fwd_rt, 0);
    chk("rst_busy", mad_busy, 0);

    // lw $1 (tnew 2) then addu $2,$1,$3
    wr(1, 2);
    #1 chk("lw_stall", stall, 0);
    step();
    rd(1, 1, 3, 1);
    d_wen = 1'b1; d_a3 = 5'd2; d_tnew = 3'd1;
    #1 chk("lw_use_stall", stall, 1);
    chk("lw_use_fwd", fwd_rs, 0);
    step();
    chk("lw_use2_stall", stall, 0);
    chk("lw_use2_fwd", fwd_rs, 0);
    drain();

    // addu $1 (tnew 1) then beq $1,$1 (tuse 0)
    wr(1, 1);
    step();
    rd(1, 0, 1, 0);
    #1 chk("beq_stall", stall, 1);
    step();
    chk("beq2_stall", stall, 0);
    chk("beq2_fwd_rs", fwd_rs, 2);
    chk("beq2_fwd_rt", fwd_rt, 2);
    drain();

    // ori $0 then reader of $0
    wr(0, 1);
    step();
    rd(0, 0, 0, 0);
    #1 chk("r0_stall", stall, 0);
    chk("r0_fwd_rs", fwd_rs, 0);
    chk("r0_fwd_rt", fwd_rt, 0);
    step();
    chk("r0b_stall", stall, 0);
    chk("r0b_fwd", fwd_rs, 0);
    drain();

    // $7 in M (tnew 0) and in E (tnew 1)
    wr(7, 1);
    step();
    wr(7, 1);
    step();
    rd(7, 1, 0, 0);
    #1 chk("young_t1_stall", stall, 0);
    chk("young_t1_fwd", fwd_rs, 0);
    d_rs_tuse = 3'd0;
    #1 chk("young_t0_stall", stall, 1);
    chk("young_t0_fwd", fwd_rs, 0);
    drain();

    // mult then mflo
    clr();
    d_valid = 1'b1; d_mad_start = 1'b1; d_mad_use = 1'b1;
    #1 chk("mult_stall", stall, 0);
    chk("mult_busy0", mad_busy, 0);
    step();
    clr();
    d_valid = 1'b1; d_mad_use = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mul_busy%0d", i), mad_busy, 1);
      chk($sformatf("mul_stall%0d", i), stall, 1);
      step();
    end
    chk("mul_done_busy", mad_busy, 0);
    chk("mul_done_stall", stall, 0);
    drain();

    // div then mflo
    clr();
    d_valid = 1'b1; d_mad_start = 1'b1;
    d_mad_div = 1'b1; d_mad_use = 1'b1;
    step();
    clr();
    d_valid = 1'b1; d_mad_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("div_busy%0d", i), mad_busy, 1);
      step();
    end
    chk("div_done_busy", mad_busy, 0);
    chk("div_done_stall", stall, 0);
    drain();

    // div then reset three cycles later
    clr();
    d_valid = 1'b1; d_mad_start = 1'b1; d_mad_div = 1'b1;
    step();
    clr();
    step();
    step();
    chk("rstmad_busy", mad_busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1 chk("rstmad_clr", mad_busy, 0);
    drain();

    // flush during lw stall: flush wins, s[1] is a bubble
    wr(1, 2);
    step();
    rd(1, 1, 0, 0);
    d_wen = 1'b1; d_a3 = 5'd2; d_tnew = 3'd1;
    #1 chk("fl_pre_stall", stall, 1);
    flush = 1'b1;
    #1 chk("fl_stall", stall, 0);
    step();
    rd(2, 0, 0, 0);
    #1 chk("fl_bubble_stall", stall, 0);
    chk("fl_bubble_fwd", fwd_rs, 0);
    drain();

    // flushed mult must not start the MAD counter
    clr();
    d_valid = 1'b1; d_mad_start = 1'b1; flush = 1'b1;
    step();
    clr();
    #1 chk("fl_mad_busy", mad_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
